// File: rtl/axi_cmd_master.sv
// AXI4 initiator: turns single read/write burst commands into AR/R or AW/W/B transactions,
// one transaction outstanding, with a ready/valid write stream in and read stream out.
module axi_cmd_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [ID_WIDTH-1:0]   cmd_id_i,

  input  logic [DATA_WIDTH-1:0] wr_tdata_i,
  input  logic [STRB_WIDTH-1:0] wr_tstrb_i,
  input  logic                  wr_tvalid_i,
  output logic                  wr_tready_o,

  output logic [DATA_WIDTH-1:0] rd_tdata_o,
  output logic                  rd_tlast_o,
  output logic                  rd_tvalid_o,
  input  logic                  rd_tready_i,

  output logic                  sts_valid_o,
  output logic                  sts_write_o,
  output logic [1:0]            sts_resp_o,
  output logic [ID_WIDTH-1:0]   sts_id_o,

  output logic [ID_WIDTH-1:0]   m_axi_awid_o,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
  output logic [7:0]            m_axi_awlen_o,
  output logic [2:0]            m_axi_awsize_o,
  output logic [1:0]            m_axi_awburst_o,
  output logic                  m_axi_awlock_o,
  output logic [3:0]            m_axi_awcache_o,
  output logic [2:0]            m_axi_awprot_o,
  output logic                  m_axi_awvalid_o,
  input  logic                  m_axi_awready_i,

  output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb_o,
  output logic                  m_axi_wlast_o,
  output logic                  m_axi_wvalid_o,
  input  logic                  m_axi_wready_i,

  input  logic [ID_WIDTH-1:0]   m_axi_bid_i,
  input  logic [1:0]            m_axi_bresp_i,
  input  logic                  m_axi_bvalid_i,
  output logic                  m_axi_bready_o,

  output logic [ID_WIDTH-1:0]   m_axi_arid_o,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [7:0]            m_axi_arlen_o,
  output logic [2:0]            m_axi_arsize_o,
  output logic [1:0]            m_axi_arburst_o,
  output logic                  m_axi_arlock_o,
  output logic [3:0]            m_axi_arcache_o,
  output logic [2:0]            m_axi_arprot_o,
  output logic                  m_axi_arvalid_o,
  input  logic                  m_axi_arready_i,

  input  logic [ID_WIDTH-1:0]   m_axi_rid_i,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
  input  logic [1:0]            m_axi_rresp_i,
  input  logic                  m_axi_rlast_i,
  input  logic                  m_axi_rvalid_i,
  output logic                  m_axi_rready_o
);

  localparam logic [2:0]            AxSize    = 3'($clog2(STRB_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [1:0]            RespOkay  = 2'b00;
  localparam logic [1:0]            RespSlv   = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StWrAddr, StWrData, StWrResp, StRdAddr, StRdData, StErr
  } state_e;

  state_e                state_q;
  logic                  cmd_ready_q;
  logic                  awvalid_q;
  logic                  arvalid_q;
  logic                  bready_q;
  logic                  sts_valid_q;
  logic                  sts_write_q;
  logic [1:0]            sts_resp_q;
  logic [ID_WIDTH-1:0]   sts_id_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            beat_cnt_q;
  logic [1:0]            rresp_q;

  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic [31:0]           page_end;
  logic                  crosses_4k;
  logic                  cmd_hs;
  logic                  w_hs;
  logic                  r_hs;
  logic                  in_wr_data;
  logic                  in_rd_data;
  logic                  framing_err;
  logic [1:0]            rresp_d;
  logic                  unused_ids;

  assign unused_ids = ^{m_axi_bid_i, m_axi_rid_i};

  assign addr_aligned = cmd_addr_i & AlignMask;
  // Byte offset just past the burst, relative to the start of its 4 KB page.
  assign page_end   = 32'(addr_aligned[11:0]) + (32'(cmd_len_i) + 32'd1) * STRB_WIDTH;
  assign crosses_4k = page_end > 32'd4096;

  assign in_wr_data = (state_q == StWrData);
  assign in_rd_data = (state_q == StRdData);
  assign cmd_hs     = cmd_valid_i & cmd_ready_q;
  assign w_hs       = m_axi_wvalid_o & m_axi_wready_i;
  assign r_hs       = m_axi_rvalid_i & m_axi_rready_o;

  // rlast must coincide exactly with the beat counter reaching zero.
  assign framing_err = m_axi_rlast_i ^ (beat_cnt_q == 8'd0);

  always_comb begin
    rresp_d = RespOkay;
    if (rresp_q != RespOkay) begin
      rresp_d = rresp_q;
    end else if (m_axi_rresp_i != RespOkay) begin
      rresp_d = m_axi_rresp_i;
    end else if (framing_err) begin
      rresp_d = RespSlv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      sts_valid_q <= 1'b0;
      sts_write_q <= 1'b0;
      sts_resp_q  <= RespOkay;
      sts_id_q    <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      beat_cnt_q  <= '0;
      rresp_q     <= RespOkay;
    end else begin
      sts_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_hs) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write_i;
            addr_q      <= addr_aligned;
            len_q       <= cmd_len_i;
            id_q        <= cmd_id_i;
            rresp_q     <= RespOkay;
            if (crosses_4k) begin
              state_q <= StErr;
            end else if (cmd_write_i) begin
              state_q   <= StWrAddr;
              awvalid_q <= 1'b1;
            end else begin
              state_q   <= StRdAddr;
              arvalid_q <= 1'b1;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        StWrAddr: begin
          if (m_axi_awready_i) begin
            awvalid_q  <= 1'b0;
            beat_cnt_q <= len_q;
            state_q    <= StWrData;
          end
        end
        StWrData: begin
          if (w_hs) begin
            if (beat_cnt_q == 8'd0) begin
              bready_q <= 1'b1;
              state_q  <= StWrResp;
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
            end
          end
        end
        StWrResp: begin
          if (m_axi_bvalid_i) begin
            bready_q    <= 1'b0;
            sts_valid_q <= 1'b1;
            sts_write_q <= 1'b1;
            sts_resp_q  <= m_axi_bresp_i;
            sts_id_q    <= id_q;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StRdAddr: begin
          if (m_axi_arready_i) begin
            arvalid_q  <= 1'b0;
            beat_cnt_q <= len_q;
            state_q    <= StRdData;
          end
        end
        StRdData: begin
          if (r_hs) begin
            rresp_q <= rresp_d;
            // Extra beats past the expected count hold the counter at zero.
            if (beat_cnt_q != 8'd0) begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
            end
            if (m_axi_rlast_i) begin
              sts_valid_q <= 1'b1;
              sts_write_q <= 1'b0;
              sts_resp_q  <= rresp_d;
              sts_id_q    <= id_q;
              cmd_ready_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        StErr: begin
          sts_valid_q <= 1'b1;
          sts_write_q <= write_q;
          sts_resp_q  <= RespSlv;
          sts_id_q    <= id_q;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;

  assign sts_valid_o = sts_valid_q;
  assign sts_write_o = sts_write_q;
  assign sts_resp_o  = sts_resp_q;
  assign sts_id_o    = sts_id_q;

  assign m_axi_awid_o    = id_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = len_q;
  assign m_axi_awsize_o  = AxSize;
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_awlock_o  = 1'b0;
  assign m_axi_awcache_o = 4'b0011;
  assign m_axi_awprot_o  = 3'b000;
  assign m_axi_awvalid_o = awvalid_q;

  assign m_axi_wdata_o  = wr_tdata_i;
  assign m_axi_wstrb_o  = wr_tstrb_i;
  assign m_axi_wlast_o  = in_wr_data & (beat_cnt_q == 8'd0);
  assign m_axi_wvalid_o = in_wr_data & wr_tvalid_i;
  assign wr_tready_o    = in_wr_data & m_axi_wready_i;

  assign m_axi_bready_o = bready_q;

  assign m_axi_arid_o    = id_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = len_q;
  assign m_axi_arsize_o  = AxSize;
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = 4'b0011;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_arvalid_o = arvalid_q;

  assign rd_tdata_o     = m_axi_rdata_i;
  assign rd_tlast_o     = m_axi_rlast_i;
  assign rd_tvalid_o    = in_rd_data & m_axi_rvalid_i;
  assign m_axi_rready_o = in_rd_data & rd_tready_i;

endmodule

// File: tb/tb_axi_cmd_master.sv
// Bench for axi_cmd_master: small AXI4 memory slave model plus status and read-data scoreboards.
module tb_axi_cmd_master;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic [DW-1:0] wr_tdata;
  logic [SW-1:0] wr_tstrb;
  logic          wr_tvalid, wr_tready;
  logic [DW-1:0] rd_tdata;
  logic          rd_tlast, rd_tvalid, rd_tready;
  logic          sts_valid, sts_write;
  logic [1:0]    sts_resp;
  logic [IW-1:0] sts_id;

  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock;
  logic [3:0]    awcache, arcache;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  axi_cmd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_id_i(cmd_id),
    .wr_tdata_i(wr_tdata), .wr_tstrb_i(wr_tstrb), .wr_tvalid_i(wr_tvalid),
    .wr_tready_o(wr_tready),
    .rd_tdata_o(rd_tdata), .rd_tlast_o(rd_tlast), .rd_tvalid_o(rd_tvalid),
    .rd_tready_i(rd_tready),
    .sts_valid_o(sts_valid), .sts_write_o(sts_write), .sts_resp_o(sts_resp), .sts_id_o(sts_id),
    .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen),
    .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock),
    .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awvalid_o(awvalid),
    .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen),
    .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock),
    .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot), .m_axi_arvalid_o(arvalid),
    .m_axi_arready_i(arready),
    .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [0:1023];
  int          aw_delay = 0;
  logic [1:0]  bresp_force = 2'b00;
  int          early_last = -1;
  int          aw_wait = 0;
  int          aw_hs_cnt = 0;
  int          ar_hs_cnt = 0;
  int          wlast_errs = 0;
  logic        s_awready, s_arready, s_bvalid, r_active;
  logic [1:0]  s_bresp;
  logic [IW-1:0] s_bid;
  logic [9:0]  w_ptr, r_ptr;
  logic [7:0]  w_beat, aw_len_l, r_beat, r_last_beat;
  logic [AW-1:0] last_awaddr;
  logic [7:0]  last_awlen;

  assign awready = s_awready;
  assign arready = s_arready;
  assign wready  = 1'b1;
  assign bvalid  = s_bvalid;
  assign bresp   = s_bresp;
  assign bid     = s_bid;
  assign rvalid  = r_active;
  assign rdata   = mem[r_ptr];
  assign rlast   = (r_beat == r_last_beat);
  assign rresp   = 2'b00;
  assign rid     = '0;

  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      s_awready <= 1'b0;
      s_arready <= 1'b0;
      s_bvalid  <= 1'b0;
      r_active  <= 1'b0;
      aw_wait   <= 0;
      w_beat    <= '0;
    end else begin
      if (awvalid && !s_awready) begin
        if (aw_wait >= aw_delay) s_awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (awvalid && s_awready) begin
        s_awready   <= 1'b0;
        aw_wait     <= 0;
        aw_hs_cnt   <= aw_hs_cnt + 1;
        last_awaddr <= awaddr;
        last_awlen  <= awlen;
        w_ptr       <= awaddr[11:2];
        w_beat      <= '0;
        aw_len_l    <= awlen;
      end
      if (wvalid && wready) begin
        for (int b = 0; b < SW; b++)
          if (wstrb[b]) mem[w_ptr][8*b +: 8] <= wdata[8*b +: 8];
        w_ptr  <= w_ptr + 10'd1;
        w_beat <= w_beat + 8'd1;
        if (wlast != (w_beat == aw_len_l)) wlast_errs <= wlast_errs + 1;
        if (wlast) begin
          s_bvalid <= 1'b1;
          s_bresp  <= bresp_force;
          s_bid    <= awid;
        end
      end
      if (s_bvalid && bready) s_bvalid <= 1'b0;
      if (arvalid && !s_arready) s_arready <= 1'b1;
      if (arvalid && s_arready) begin
        s_arready   <= 1'b0;
        ar_hs_cnt   <= ar_hs_cnt + 1;
        r_active    <= 1'b1;
        r_ptr       <= araddr[11:2];
        r_beat      <= '0;
        r_last_beat <= (early_last >= 0) ? early_last[7:0] : arlen;
      end
      if (r_active && rready) begin
        r_ptr  <= r_ptr + 10'd1;
        r_beat <= r_beat + 8'd1;
        if (rlast) r_active <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic write; logic [1:0] resp; logic [7:0] id; } sts_t;
  typedef struct packed { logic [31:0] data; logic last; } rd_t;
  sts_t sts_q[$];
  rd_t  rd_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sts_seen = 0;
  logic rd_toggle = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sts_t es;
    rd_t  er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sts_valid) begin
          sts_seen++;
          if (sts_q.size() == 0) begin
            check_eq("sts_unexpected", sts_valid, 0);
          end else begin
            es = sts_q.pop_front();
            check_eq("sts_write", sts_write, es.write);
            check_eq("sts_resp", sts_resp, es.resp);
            check_eq("sts_id", sts_id, es.id);
            check_eq("sts_cmd_ready", cmd_ready, 1);
          end
        end
        if (rd_tvalid && rd_tready) begin
          if (rd_q.size() == 0) begin
            check_eq("rd_unexpected", rd_tvalid, 0);
          end else begin
            er = rd_q.pop_front();
            check_eq("rd_data", rd_tdata, er.data);
            check_eq("rd_last", rd_tlast, er.last);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [IW-1:0] id);
    logic got = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      got = cmd_ready;
      tick();
      if (got) break;
    end
    if (!got) check_eq("cmd_accept_timeout", got, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [DW-1:0] d);
    logic got = 1'b0;
    wr_tvalid = 1'b1; wr_tdata = d; wr_tstrb = '1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      got = wr_tvalid && wr_tready;
      tick();
      if (got) break;
    end
    if (!got) check_eq("wr_beat_timeout", got, 1);
    wr_tvalid = 1'b0;
  endtask

  task automatic wait_sts(input int target);
    for (int i = 0; i < 200; i++) begin
      if (sts_seen >= target) break;
      rd_tready = rd_toggle ? ~rd_tready : 1'b1;
      tick();
    end
    check_eq("sts_arrived", sts_seen >= target, 1);
  endtask

  int aw0, ar0;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wr_tvalid = 1'b0; wr_tdata = '0; wr_tstrb = '0; rd_tready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_wr_tready", wr_tready, 0);
    check_eq("rst_rd_tvalid", rd_tvalid, 0);
    check_eq("rst_sts", {sts_valid, sts_write, sts_resp, sts_id}, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_eq("release_cmd_ready", cmd_ready, 1);
    tick();

    // single-beat write, AW delayed
    aw_delay = 3;
    sts_q.push_back('{write: 1'b1, resp: 2'b00, id: 8'h11});
    send_cmd(1'b1, 16'h0100, 8'd0, 8'h11);
    push_wr(32'hDEADBEEF);
    wait_sts(1);
    aw_delay = 0;
    check_eq("w1_awaddr", last_awaddr, 16'h0100);
    check_eq("w1_awlen", last_awlen, 0);
    check_eq("w1_fixed", {awsize, awburst, awlock, awcache, awprot}, {3'd2, 2'b01, 1'b0, 4'b0011, 3'd0});

    // 4-beat write then read back with throttled consumer
    sts_q.push_back('{write: 1'b1, resp: 2'b00, id: 8'h22});
    send_cmd(1'b1, 16'h0100, 8'd3, 8'h22);
    for (int i = 1; i <= 4; i++) push_wr(32'(i));
    wait_sts(2);
    for (int i = 1; i <= 4; i++) rd_q.push_back('{data: 32'(i), last: (i == 4)});
    sts_q.push_back('{write: 1'b0, resp: 2'b00, id: 8'h33});
    rd_toggle = 1'b1; rd_tready = 1'b0;
    send_cmd(1'b0, 16'h0100, 8'd3, 8'h33);
    wait_sts(3);
    rd_toggle = 1'b0;
    check_eq("rd4_drained", rd_q.size(), 0);

    // 4 KB crossing, write then read
    aw0 = aw_hs_cnt; ar0 = ar_hs_cnt;
    sts_q.push_back('{write: 1'b1, resp: 2'b10, id: 8'h44});
    send_cmd(1'b1, 16'h0FF8, 8'd3, 8'h44);
    @(negedge clk);
    check_eq("cross_awvalid", awvalid, 0);
    tick();
    wait_sts(4);
    sts_q.push_back('{write: 1'b0, resp: 2'b10, id: 8'h45});
    send_cmd(1'b0, 16'h0FF8, 8'd3, 8'h45);
    wait_sts(5);
    check_eq("cross_no_aw", aw_hs_cnt, aw0);
    check_eq("cross_no_ar", ar_hs_cnt, ar0);

    // burst ending exactly at the page boundary is legal
    sts_q.push_back('{write: 1'b1, resp: 2'b00, id: 8'h46});
    send_cmd(1'b1, 16'h0FF0, 8'd3, 8'h46);
    for (int i = 0; i < 4; i++) push_wr(32'hC0 + 32'(i));
    wait_sts(6);
    check_eq("edge_awaddr", last_awaddr, 16'h0FF0);

    // SLVERR on B, unaligned address
    bresp_force = 2'b10;
    sts_q.push_back('{write: 1'b1, resp: 2'b10, id: 8'h5A});
    send_cmd(1'b1, 16'h0206, 8'd0, 8'h5A);
    push_wr(32'h12345678);
    wait_sts(7);
    bresp_force = 2'b00;
    check_eq("align_awaddr", last_awaddr, 16'h0204);

    // early rlast on beat 2 of 4
    early_last = 1;
    rd_q.push_back('{data: 32'd1, last: 1'b0});
    rd_q.push_back('{data: 32'd2, last: 1'b1});
    sts_q.push_back('{write: 1'b0, resp: 2'b10, id: 8'h61});
    rd_tready = 1'b1;
    send_cmd(1'b0, 16'h0100, 8'd3, 8'h61);
    wait_sts(8);
    early_last = -1;
    check_eq("early_drained", rd_q.size(), 0);
    rd_q.push_back('{data: 32'd1, last: 1'b1});
    sts_q.push_back('{write: 1'b0, resp: 2'b00, id: 8'h62});
    send_cmd(1'b0, 16'h0100, 8'd0, 8'h62);
    wait_sts(9);

    // reset during beat 2 of a 4-beat write
    send_cmd(1'b1, 16'h0200, 8'd3, 8'h70);
    push_wr(32'hA0);
    wr_tvalid = 1'b1; wr_tdata = 32'hA1; wr_tstrb = '1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("midrst_awvalid", awvalid, 0);
    check_eq("midrst_wvalid", wvalid, 0);
    check_eq("midrst_wr_tready", wr_tready, 0);
    check_eq("midrst_sts_valid", sts_valid, 0);
    wr_tvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_eq("midrst_cmd_ready", cmd_ready, 1);
    tick();
    sts_q.push_back('{write: 1'b1, resp: 2'b00, id: 8'h71});
    send_cmd(1'b1, 16'h0200, 8'd1, 8'h71);
    push_wr(32'hB0);
    push_wr(32'hB1);
    wait_sts(10);
    rd_q.push_back('{data: 32'hB0, last: 1'b0});
    rd_q.push_back('{data: 32'hB1, last: 1'b1});
    sts_q.push_back('{write: 1'b0, resp: 2'b00, id: 8'h72});
    send_cmd(1'b0, 16'h0200, 8'd1, 8'h72);
    wait_sts(11);

    repeat (3) tick();
    check_eq("wlast_placement", wlast_errs, 0);
    check_eq("sts_all_seen", sts_q.size(), 0);
    check_eq("rd_all_seen", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
